demux1t4_32_stream: RTL and testbench

//  1-to-4 demultiplexer for 32-bit words: the distributing counterpart of the 4:1 result mux.

---
 rtl/demux1t4_32_stream.sv | 77 +++++++
 tb/tb_demux1t4_32_stream.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/demux1t4_32_stream.sv
// 1-to-4 stream demultiplexer: one input channel steered by s into four lanes.
// Each lane has its own one-entry register slice. Optional lane counters: DEMUX4_CNT_EN.
module demux1t4_32_stream #(
  parameter int unsigned DW    = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         s,
  input  logic [DW-1:0]      in_data,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [4*DW-1:0]    o_data,
  output logic [3:0]         o_valid,
  input  logic [3:0]         o_ready
`ifdef DEMUX4_CNT_EN
  ,
  input  logic               cnt_clr,
  output logic [4*CNT_W-1:0] cnt
`endif
);

  logic [3:0][DW-1:0] data_q;
  logic [3:0]         valid_q;
  logic [3:0]         load;
  logic [3:0]         xfer;

  // Ready depends only on the selected lane's slice state, never on in_valid.
  assign in_ready = ~valid_q[s] | o_ready[s];

  always_comb begin
    xfer    = valid_q & o_ready;
    load    = 4'b0000;
    load[s] = in_valid & in_ready;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 4'b0000;
      data_q  <= '0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (load[k]) begin
          data_q[k]  <= in_data;
          valid_q[k] <= 1'b1;
        end else if (xfer[k]) begin
          valid_q[k] <= 1'b0;
        end
      end
    end
  end

  assign o_data  = data_q;
  assign o_valid = valid_q;

`ifdef DEMUX4_CNT_EN
  logic [3:0][CNT_W-1:0] cnt_q;

  // Clear takes priority over a same-cycle delivery.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (cnt_clr) begin
          cnt_q[k] <= '0;
        end else if (xfer[k]) begin
          cnt_q[k] <= cnt_q[k] + CNT_W'(1);
        end
      end
    end
  end

  assign cnt = cnt_q;
`endif

endmodule

// File: tb/tb_demux1t4_32_stream.sv
// Scoreboard bench for demux1t4_32_stream: per-lane expected-word queues filled on input
// acceptance, drained and compared by an independent negedge monitor.
module tb_demux1t4_32_stream;
  localparam int DW    = 32;
  localparam int CNT_W = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [1:0]      s;
  logic [DW-1:0]   in_data;
  logic            in_valid;
  logic            in_ready;
  logic [4*DW-1:0] o_data;
  logic [3:0]      o_valid;
  logic [3:0]      o_ready;
`ifdef DEMUX4_CNT_EN
  logic               cnt_clr;
  logic [4*CNT_W-1:0] cnt;
  int unsigned        mcnt [4];
`endif

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] q [4][$];

  always #5 clk = ~clk;

  demux1t4_32_stream #(.DW(DW), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .s        (s),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .o_data   (o_data),
    .o_valid  (o_valid),
    .o_ready  (o_ready)
`ifdef DEMUX4_CNT_EN
    ,
    .cnt_clr  (cnt_clr),
    .cnt      (cnt)
`endif
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] lane(input int k);
    return o_data[k*DW +: DW];
  endfunction

  // One clock: decide acceptance mid-cycle, record it at the edge, return just after the edge.
  task automatic cycle(output bit acc);
    @(negedge clk);
    acc = in_valid && in_ready && rst_n;
    @(posedge clk);
    if (acc) q[s].push_back(in_data);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("reset_o_valid", o_valid, 4'b0000);
    chk("reset_o_data", (o_data == '0), 1'b1);
    for (int k = 0; k < 4; k++) q[k].delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    chk("reset_in_ready", in_ready, 1'b1);
  endtask

  // Monitor: model says a lane is presenting a word whenever its queue is non-empty.
  initial begin
    bit             held [4];
    logic [DW-1:0]  held_data [4];
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        for (int k = 0; k < 4; k++) held[k] = 1'b0;
`ifdef DEMUX4_CNT_EN
        for (int k = 0; k < 4; k++) mcnt[k] = 0;
`endif
      end else begin
        for (int k = 0; k < 4; k++) begin
          chk($sformatf("o_valid[%0d]", k), o_valid[k], q[k].size() != 0);
          if (o_valid[k] && q[k].size() != 0)
            chk($sformatf("o_data[%0d]", k), lane(k), q[k][0]);
          if (held[k])
            chk($sformatf("stall_hold[%0d]", k), {o_valid[k], lane(k)}, {1'b1, held_data[k]});
`ifdef DEMUX4_CNT_EN
          chk($sformatf("cnt[%0d]", k), cnt[k*CNT_W +: CNT_W], mcnt[k]);
`endif
        end
        chk("in_ready", in_ready, (q[s].size() == 0) || o_ready[s]);
        for (int k = 0; k < 4; k++) begin
          held[k]      = o_valid[k] && !o_ready[k];
          held_data[k] = lane(k);
          if (o_valid[k] && o_ready[k] && q[k].size() != 0) void'(q[k].pop_front());
`ifdef DEMUX4_CNT_EN
          if (cnt_clr) mcnt[k] = 0;
          else if (o_valid[k] && o_ready[k]) mcnt[k] = (mcnt[k] + 1) % (1 << CNT_W);
`endif
        end
      end
    end
  end

  initial begin
    bit acc;
    s = 2'd0; in_data = '0; in_valid = 1'b0; o_ready = 4'b0000;
`ifdef DEMUX4_CNT_EN
    cnt_clr = 1'b0;
`endif
    #2;
    do_reset();

    // Single word to lane 2.
    s = 2'd2; in_data = 32'hDEAD_BEEF; in_valid = 1'b1; o_ready = 4'b0100;
    cycle(acc);
    chk("single_valid", o_valid, 4'b0100);
    chk("single_data", lane(2), 32'hDEAD_BEEF);
    in_valid = 1'b0;
    cycle(acc);
    chk("single_drain", o_valid, 4'b0000);

    // Backpressure on lane 1, lane 3 still usable.
    o_ready = 4'b0000; s = 2'd1; in_data = 32'h11; in_valid = 1'b1;
    cycle(acc);
    in_data = 32'h22;
    #1 chk("bp_in_ready_full", in_ready, 1'b0);
    cycle(acc);
    chk("bp_hold_valid", o_valid, 4'b0010);
    chk("bp_hold_data", lane(1), 32'h11);
    s = 2'd3; in_data = 32'h33;
    #1 chk("bp_in_ready_other", in_ready, 1'b1);
    cycle(acc);
    chk("bp_lane3_valid", o_valid, 4'b1010);
    chk("bp_lane3_data", lane(3), 32'h33);
    in_valid = 1'b0; o_ready = 4'b1111;
    cycle(acc);
    chk("bp_drain", o_valid, 4'b0000);

    // Back-to-back streaming into lane 0.
    o_ready = 4'b0001; s = 2'd0;
    for (int i = 0; i < 8; i++) begin
      in_data = DW'(i); in_valid = 1'b1;
      #1 chk("stream_in_ready", in_ready, 1'b1);
      cycle(acc);
      chk("stream_data", {o_valid[0], lane(0)}, {1'b1, DW'(i)});
    end
    in_valid = 1'b0;
    cycle(acc);
    chk("stream_end", o_valid, 4'b0000);

    // Reset mid-run with all lanes full.
    o_ready = 4'b0000; in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      s = 2'(k); in_data = 32'hA000_0000 + DW'(k);
      cycle(acc);
    end
    in_valid = 1'b0;
    chk("fill_all", o_valid, 4'b1111);
    do_reset();

    // Random traffic; an unaccepted word is held stable.
    acc = 1'b1;
    for (int i = 0; i < 10000; i++) begin
      if (!(in_valid && !acc)) begin
        s        = 2'($urandom_range(0, 3));
        in_data  = $urandom;
        in_valid = ($urandom_range(0, 9) < 7);
      end
      o_ready = 4'($urandom_range(0, 15));
`ifdef DEMUX4_CNT_EN
      cnt_clr = ($urandom_range(0, 31) == 0);
`endif
      cycle(acc);
    end
    in_valid = 1'b0; o_ready = 4'b1111;
`ifdef DEMUX4_CNT_EN
    cnt_clr = 1'b0;
`endif
    cycle(acc);
    cycle(acc);
    chk("final_empty", q[0].size() + q[1].size() + q[2].size() + q[3].size(), 0);

`ifdef DEMUX4_CNT_EN
    // Counter wrap and clear-over-increment on lane 2.
    do_reset();
    o_ready = 4'b0100; s = 2'd2; in_valid = 1'b1;
    for (int i = 0; i < 17; i++) begin
      in_data = $urandom;
      cycle(acc);
    end
    in_valid = 1'b0;
    cycle(acc);
    chk("cnt_wrap", cnt[2*CNT_W +: CNT_W], 1);
    in_valid = 1'b1; in_data = 32'h5A5A;
    cycle(acc);
    in_valid = 1'b0; cnt_clr = 1'b1;
    cycle(acc);
    cnt_clr = 1'b0;
    chk("cnt_clr_wins", cnt[2*CNT_W +: CNT_W], 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
